// File: rtl/dataout_pkg.sv
// Shared types and defaults for the dataout output path.
package dataout_pkg;

  localparam int DATA_W        = 8;
  localparam int DEPTH_DEFAULT = 16;

  typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/dataout_fifo_mem.sv
// Byte storage for the dataout FIFO: synchronous write, asynchronous read.
module dataout_fifo_mem
  import dataout_pkg::*;
#(
  parameter int  DEPTH = DEPTH_DEFAULT,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] wr_addr,
  input  data_t            wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output data_t            rd_data
);

  data_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/dataout_fifo.sv
// Output byte FIFO feeding the dataout port: valid/full write side,
// ready/read pop side, occupancy and sticky overflow/underflow status.
module dataout_fifo
  import dataout_pkg::*;
#(
  parameter int  DEPTH = DEPTH_DEFAULT,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  data_t            in_data,
  output logic             in_full,
  output logic             ready,
  input  logic             read,
  output data_t            data_out,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             underflow
);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic             drop;
  data_t            head;

  assign in_full = (count == CNT_W'(DEPTH));
  assign ready   = (count != '0);

  // A pop in the same cycle frees a slot, so a write at full is still accepted.
  assign pop  = read & ready;
  assign push = in_valid & (~in_full | pop);
  assign drop = in_valid & in_full & ~pop;

  dataout_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .we      (push & ~rst),
    .wr_addr (wr_ptr),
    .wr_data (in_data),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

  assign data_out = ready ? head : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (drop)          overflow  <= 1'b1;
      if (read & ~ready) underflow <= 1'b1;
    end
  end

endmodule
